// File: rtl/fb_write_scheduler_if.sv
// Bundle of the animator request port, clear control and framebuffer write port
// shared between the request source (master) and fb_write_scheduler (slave).
interface fb_write_scheduler_if;
  logic        clear_req;
  logic        anim_req;
  logic [10:0] anim_x;
  logic [10:0] anim_y;
  logic        anim_color;
  logic        anim_grant;
  logic [10:0] fb_x;
  logic [10:0] fb_y;
  logic        fb_color;
  logic        fb_write;
  logic        clear_busy;
  logic        clear_done;

  modport master (
    output clear_req, anim_req, anim_x, anim_y, anim_color,
    input  anim_grant, fb_x, fb_y, fb_color, fb_write, clear_busy, clear_done
  );

  modport slave (
    input  clear_req, anim_req, anim_x, anim_y, anim_color,
    output anim_grant, fb_x, fb_y, fb_color, fb_write, clear_busy, clear_done
  );
endinterface

// File: rtl/fb_write_scheduler.sv
// Arbitrates the single framebuffer write port between animator pixel writes and a
// full-screen blackout sweep. Optional macro FB_SCHED_BOUNDS_CHECK_EN drops off-screen animator writes.
module fb_write_scheduler #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input logic clk,
  input logic reset_n,
  fb_write_scheduler_if.slave bus
);

  typedef enum logic {Idle, Clear} state_t;

  localparam logic [10:0] XLast = 11'(WIDTH - 1);
  localparam logic [10:0] YLast = 11'(HEIGHT - 1);

  state_t      state_q, state_d;
  logic [10:0] cx_q, cx_d;
  logic [10:0] cy_q, cy_d;
  logic [10:0] fbX_q, fbX_d;
  logic [10:0] fbY_q, fbY_d;
  logic        fbColor_q, fbColor_d;
  logic        fbWrite_q, fbWrite_d;
  logic        clearDone_q, clearDone_d;
  logic        animGrant;
  logic        inRange;

  // Clear wins over a simultaneous animator request; nothing is granted during reset.
  assign animGrant = reset_n && bus.anim_req && (state_q == Idle) && !bus.clear_req;

`ifdef FB_SCHED_BOUNDS_CHECK_EN
  localparam logic [11:0] XLimit = 12'(WIDTH);
  localparam logic [11:0] YLimit = 12'(HEIGHT);
  assign inRange = ({1'b0, bus.anim_x} < XLimit) && ({1'b0, bus.anim_y} < YLimit);
`else
  assign inRange = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= Idle;
      cx_q        <= '0;
      cy_q        <= '0;
      fbX_q       <= '0;
      fbY_q       <= '0;
      fbColor_q   <= 1'b0;
      fbWrite_q   <= 1'b0;
      clearDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      fbX_q       <= fbX_d;
      fbY_q       <= fbY_d;
      fbColor_q   <= fbColor_d;
      fbWrite_q   <= fbWrite_d;
      clearDone_q <= clearDone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    fbX_d       = fbX_q;
    fbY_d       = fbY_q;
    fbColor_d   = fbColor_q;
    fbWrite_d   = 1'b0;
    clearDone_d = 1'b0;
    case (state_q)
      Idle: begin
        if (bus.clear_req) begin
          state_d = Clear;
          cx_d    = '0;
          cy_d    = '0;
        end else if (animGrant && inRange) begin
          fbX_d     = bus.anim_x;
          fbY_d     = bus.anim_y;
          fbColor_d = bus.anim_color;
          fbWrite_d = 1'b1;
        end
      end
      Clear: begin
        // Sweep is x-major; further clear requests are ignored until it finishes.
        fbX_d     = cx_q;
        fbY_d     = cy_q;
        fbColor_d = 1'b0;
        fbWrite_d = 1'b1;
        if (cx_q == XLast) begin
          cx_d = '0;
          if (cy_q == YLast) begin
            cy_d        = '0;
            state_d     = Idle;
            clearDone_d = 1'b1;
          end else begin
            cy_d = cy_q + 11'd1;
          end
        end else begin
          cx_d = cx_q + 11'd1;
        end
      end
      default: state_d = Idle;
    endcase
  end

  assign bus.anim_grant = animGrant;
  assign bus.fb_x       = fbX_q;
  assign bus.fb_y       = fbY_q;
  assign bus.fb_color   = fbColor_q;
  assign bus.fb_write   = fbWrite_q;
  assign bus.clear_busy = (state_q == Clear);
  assign bus.clear_done = clearDone_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler on a 4x3 screen: a pixel-list model checked
// every cycle, directed clear/grant/reset scenarios, then randomized traffic.
module tb_fb_write_scheduler;
  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   checkEn = 1'b0;

  fb_write_scheduler_if bus ();

  fb_write_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: a clear is just a running pixel index walked over W*H pixels.
  bit          mBusy = 1'b0;
  int          mIdx = 0;
  logic [10:0] mFbX = '0;
  logic [10:0] mFbY = '0;
  logic        mFbColor = 1'b0;
  logic        mFbWrite = 1'b0;
  logic        mDone = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mBusy = 1'b0; mIdx = 0; mFbX = '0; mFbY = '0;
      mFbColor = 1'b0; mFbWrite = 1'b0; mDone = 1'b0;
    end else if (mBusy) begin
      mFbX = 11'(mIdx % W);
      mFbY = 11'(mIdx / W);
      mFbColor = 1'b0;
      mFbWrite = 1'b1;
      mDone = (mIdx == W * H - 1);
      if (mDone) mBusy = 1'b0;
      else mIdx = mIdx + 1;
    end else begin
      mDone = 1'b0;
      mFbWrite = 1'b0;
      if (bus.clear_req) begin
        mBusy = 1'b1;
        mIdx = 0;
      end else if (bus.anim_req) begin
`ifdef FB_SCHED_BOUNDS_CHECK_EN
        if (int'(bus.anim_x) < W && int'(bus.anim_y) < H) begin
`else
        begin
`endif
          mFbX = bus.anim_x;
          mFbY = bus.anim_y;
          mFbColor = bus.anim_color;
          mFbWrite = 1'b1;
        end
      end
    end
  end

  logic [22:0] wrLog[$];
  int          doneCount = 0;
  int          doneIdx = -1;

  always @(negedge clk) begin
    logic [26:0] act, exp;
    logic        expGrant;
    if (checkEn) begin
      expGrant = reset_n && bus.anim_req && !mBusy && !bus.clear_req;
      act = {bus.anim_grant, bus.fb_write, bus.fb_x, bus.fb_y, bus.fb_color, bus.clear_busy, bus.clear_done};
      exp = {expGrant, mFbWrite, mFbX, mFbY, mFbColor, mBusy, mDone};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("[TB] FAIL cycleCheck t=%0t got=%h expected=%h", $time, act, exp);
      end
      if (bus.fb_write) wrLog.push_back({bus.fb_x, bus.fb_y, bus.fb_color});
      if (bus.clear_done) begin
        doneCount++;
        doneIdx = wrLog.size() - 1;
      end
    end
  end

  function automatic logic [22:0] pix(input int x, input int y, input int c);
    return {11'(x), 11'(y), 1'(c)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit req, input int x, input int y, input bit c);
    bus.anim_req = req;
    bus.anim_x = 11'(x);
    bus.anim_y = 11'(y);
    bus.anim_color = c;
  endtask

  // Pulses clear (optionally with an animator request held), re-requests clear at
  // sweep index reclearAt, and checks the sweep length and grant behaviour.
  task automatic runClear(input string tag, input bit holdAnim, input int reclearAt);
    int busy = 0;
    int g = 0;
    logic [22:0] expClear[12];
    expClear = '{pix(0,0,0), pix(1,0,0), pix(2,0,0), pix(3,0,0),
                 pix(0,1,0), pix(1,1,0), pix(2,1,0), pix(3,1,0),
                 pix(0,2,0), pix(1,2,0), pix(2,2,0), pix(3,2,0)};
    tick();
    wrLog.delete();
    doneCount = 0;
    doneIdx = -1;
    bus.clear_req = 1'b1;
    applyStimulus(holdAnim, 1, 2, 1'b1);
    @(negedge clk);
    checkOutput({tag, "ClearWins"}, 32'(bus.anim_grant), 0);
    tick();
    bus.clear_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.clear_busy) break;
      busy++;
      if (bus.anim_grant) g++;
      tick();
      bus.clear_req = (busy == reclearAt);
    end
    checkOutput({tag, "BusyCycles"}, 32'(busy), 12);
    checkOutput({tag, "GrantInBusy"}, 32'(g), 0);
    checkOutput({tag, "GrantAfter"}, 32'(bus.anim_grant), 32'(holdAnim));
    tick();
    applyStimulus(1'b0, 0, 0, 1'b0);
    tick();
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("%sPix%0d", tag, i), (i < wrLog.size()) ? 32'(wrLog[i]) : 32'hFFFFFFFF, 32'(expClear[i]));
    checkOutput({tag, "DoneCount"}, 32'(doneCount), 1);
    checkOutput({tag, "DoneIdx"}, 32'(doneIdx), 11);
    checkOutput({tag, "WriteCount"}, 32'(wrLog.size()), holdAnim ? 13 : 12);
    if (holdAnim)
      checkOutput({tag, "AnimAfter"}, (wrLog.size() > 12) ? 32'(wrLog[12]) : 32'hFFFFFFFF, 32'(pix(1,2,1)));
  endtask

  initial begin
    bit lastGrant;
    bus.clear_req = 1'b0;
    applyStimulus(1'b1, 2, 1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ResetGrant", 32'(bus.anim_grant), 0);
    checkOutput("ResetWrite", 32'(bus.fb_write), 0);
    checkOutput("ResetXY", 32'({bus.fb_x, bus.fb_y}), 0);
    checkOutput("ResetBusyDone", 32'({bus.clear_busy, bus.clear_done, bus.fb_color}), 0);
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkEn = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    runClear("Clr", 1'b0, -1);

    tick();
    applyStimulus(1'b1, 2, 1, 1'b1);
    @(negedge clk);
    checkOutput("AnimGrant", 32'(bus.anim_grant), 1);
    tick();
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("AnimWrite", 32'({bus.fb_write, bus.fb_x, bus.fb_y, bus.fb_color}), 32'({1'b1, 11'd2, 11'd1, 1'b1}));

    runClear("Hold", 1'b1, 5);

    tick();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (6) tick();
    #1;
    reset_n = 1'b0;
    applyStimulus(1'b1, 3, 1, 1'b1);
    #1;
    checkOutput("MidResetWrite", 32'(bus.fb_write), 0);
    checkOutput("MidResetBusy", 32'(bus.clear_busy), 0);
    checkOutput("MidResetGrant", 32'(bus.anim_grant), 0);
    tick();
    reset_n = 1'b1;
    wrLog.delete();
    @(negedge clk);
    checkOutput("PostResetGrant", 32'(bus.anim_grant), 1);
    tick();
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("PostResetWrite", 32'({bus.fb_write, bus.fb_x, bus.fb_y, bus.fb_color}), 32'({1'b1, 11'd3, 11'd1, 1'b1}));
    repeat (20) tick();
    checkOutput("NoResumedClear", 32'(wrLog.size()), 1);

    applyStimulus(1'b1, 4, 0, 1'b1);
    @(negedge clk);
    checkOutput("OobGrant", 32'(bus.anim_grant), 1);
    tick();
    applyStimulus(1'b0, 0, 0, 1'b0);
`ifdef FB_SCHED_BOUNDS_CHECK_EN
    checkOutput("OobWrite", 32'(bus.fb_write), 0);
`else
    checkOutput("OobWrite", 32'({bus.fb_write, bus.fb_x}), 32'({1'b1, 11'd4}));
`endif

    // Random traffic: animator data is held until granted, clear pulses are rare.
    lastGrant = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      lastGrant = bus.anim_grant;
      tick();
      bus.clear_req = ($urandom_range(0, 39) == 0);
      if (!bus.anim_req || lastGrant)
        applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    tick();
    bus.clear_req = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 Parameter WIDTH, default 640, visible columns to be cleared and bounds-checked.
REQ-002 Parameter HEIGHT, default 480, visible rows to be cleared and bounds-checked.
REQ-003 clk  input  1  system clock (CLOCK_50 domain); one clock; reset is asynchronous and active-low.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 clear_req  input  1  single-cycle pulse requesting a full-screen blackout.
REQ-006 anim_req  input  1  animator pixel-write request; held with its data until granted.
REQ-007 anim_x  input  11  animator pixel column.
REQ-008 anim_y  input  11  animator pixel row.
REQ-009 anim_color  input  1  animator pixel color.
REQ-010 anim_grant  output  1  combinational; high in the cycle the animator request is accepted.
REQ-011 fb_x  output  11  registered framebuffer write column.
REQ-012 fb_y  output  11  registered framebuffer write row.
REQ-013 fb_color  output  1  registered framebuffer pixel color.
REQ-014 fb_write  output  1  registered framebuffer write strobe.
REQ-015 clear_busy  output  1  high while state is CLEAR.
REQ-016 clear_done  output  1  registered one-cycle pulse on clear completion.

Function
REQ-017 The FSM has two states: IDLE (animator may write) and CLEAR (sweep owns the port).
REQ-018 IDLE -> CLEAR on the clock edge sampling clear_req=1; the counters cx and cy load 0 on that edge.
REQ-019 In CLEAR, each cycle drives fb_x=cx, fb_y=cy, fb_color=0, fb_write=1 on the next edge.
- Sweep order is x-major: cx increments.
- At cx=WIDTH-1, cx wraps to 0 and cy increments.
REQ-020 After the write of (WIDTH-1, HEIGHT-1) is issued, the FSM returns to IDLE and clear_done pulses for exactly one cycle, coincident with that final fb_write.
- A clear therefore takes exactly WIDTH*HEIGHT cycles with fb_write=1.
REQ-021 clear_req received while in CLEAR is ignored; the sweep is not restarted.
REQ-022 anim_grant = anim_req AND state==IDLE AND NOT clear_req; on a simultaneous clear_req and anim_req, clear wins and the animator waits.
REQ-023 On a grant, anim_x, anim_y and anim_color are registered to fb_x, fb_y and fb_color with fb_write=1 on the next edge (latency 1 cycle).
REQ-024 In any cycle with no grant and not CLEAR, fb_write=0 on the next edge and fb_x, fb_y, fb_color hold their values.
REQ-025 fb_x and fb_y never exceed WIDTH-1 and HEIGHT-1 while fb_write=1 during CLEAR.
REQ-026 A grant issued in the cycle before entry to CLEAR still produces its fb_write; clear writes begin on the following cycle.

Reset
REQ-027 While reset_n=0, the following values are forced asynchronously:
- state=IDLE, cx=cy=0.
- fb_x=fb_y=0, fb_color=0.
- fb_write=0, clear_done=0.
REQ-028 Reset asserted mid-clear aborts the sweep; the clear is not resumed after reset_n returns to 1.
REQ-029 anim_grant is 0 while reset_n=0.

Configuration
REQ-030 Macro FB_SCHED_BOUNDS_CHECK_EN behaves as follows:
- Defined: a granted animator request with anim_x>=WIDTH or anim_y>=HEIGHT is still granted (consumed), but fb_write stays 0 and fb_x, fb_y, fb_color hold.
- Not defined: all granted requests are written unchanged.

Verification (bench uses WIDTH=4, HEIGHT=3)
REQ-031 Reset release, then a clear_req pulse -> clear_busy=1 for 12 cycles; fb writes (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2), all color 0; clear_done is a single pulse with the (3,2) write.
REQ-032 IDLE, anim_req=1 with (2,1,color 1) -> anim_grant=1 the same cycle; next cycle fb_write=1, fb_x=2, fb_y=1, fb_color=1.
REQ-033 anim_req held high through a clear_req pulse -> anim_grant=0 for all 12 clear cycles, then anim_grant=1 the cycle after clear_busy falls.
REQ-034 Simultaneous clear_req and anim_req in IDLE -> anim_grant=0 and the first fb write is (0,0) color 0; a second clear_req at sweep index 5 -> the sweep still ends at (3,2) after 12 writes total.
REQ-035 reset_n pulled to 0 at sweep index 6 -> fb_write=0 and clear_busy=0 immediately; after release, no further clear writes occur and anim_req is granted.
REQ-036 With FB_SCHED_BOUNDS_CHECK_EN defined, anim_req at (4,0) -> anim_grant=1 and fb_write stays 0; without the macro -> fb_write=1 with fb_x=4.
